// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: fetch PC owner; predict-not-taken redirect, flushes, shadow drain
// Also counts accepted redirects (saturating) and flags misaligned targets.
module branch_redirect_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic            NextPCSrc_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            fetch_valid_o,
    output logic            flush_ifid_o,
    output logic            flush_idex_o,
    output logic            misaligned_o,
    output logic [31:0]     redirect_count_o
);
    typedef enum logic {RUN, SHADOW} state_t;
    state_t state_q, state_d;
    logic [1:0] shadow_q, shadow_d;
    logic [31:0] count_q;
    logic [XLEN-1:0] pc_d;
    logic take;
    always_comb begin
        take = 1'b0;
        state_d = state_q;
        shadow_d = shadow_q;
        if (state_q == RUN) begin
            take = ex_valid_i & NextPCSrc_i & rst_n;
            state_d = take ? SHADOW : RUN;
            shadow_d = take ? 2'(SHADOW_CYCLES) : shadow_q;
        end else begin
            // EX keeps draining bubbles even under a load-use stall
            shadow_d = shadow_q - 2'd1;
            state_d = (shadow_q == 2'd1) ? RUN : SHADOW;
        end
        pc_d = take ? {target_i[XLEN-1:2], 2'b00} : (stall_i ? pc_o : pc_plus4_o);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            shadow_q <= 2'd0;
            pc_o <= RESET_PC;
            fetch_valid_o <= 1'b0;
            misaligned_o <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            shadow_q <= shadow_d;
            pc_o <= pc_d;
            fetch_valid_o <= 1'b1;
            misaligned_o <= take & (target_i[1:0] != 2'b00);
            count_q <= (take && count_q != 32'hFFFF_FFFF) ? count_q + 32'd1 : count_q;
        end
    end
    assign pc_plus4_o = pc_o + XLEN'(4);
    assign flush_ifid_o = take;
    assign flush_idex_o = take;
    assign redirect_count_o = count_q;
endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb_branch_redirect_unit: scoreboard bench; reference model pushes expected state per cycle
module tb_branch_redirect_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_i = 1'b0;
    logic ex_valid_i = 1'b0;
    logic NextPCSrc_i = 1'b0;
    logic [31:0] target_i = '0;
    logic [31:0] pc_o, pc_plus4_o, redirect_count_o;
    logic fetch_valid_o, flush_ifid_o, flush_idex_o, misaligned_o;
    typedef struct {
        logic [31:0] pc;
        logic fv;
        logic mis;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_cnt = '0;
    logic m_fv = 1'b0;
    logic m_mis = 1'b0;
    int m_block = 0;
    branch_redirect_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
        .NextPCSrc_i(NextPCSrc_i), .target_i(target_i), .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o), .fetch_valid_o(fetch_valid_o),
        .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
        .misaligned_o(misaligned_o), .redirect_count_o(redirect_count_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic s, input logic ev, input logic nps, input logic [31:0] tgt);
        logic tk;
        exp_t e;
        @(negedge clk);
        rst_n = r;
        stall_i = s;
        ex_valid_i = ev;
        NextPCSrc_i = nps;
        target_i = tgt;
        #1;
        tk = r && ev && nps && m_block == 0;
        check("flush_ifid", 32'(flush_ifid_o), 32'(tk));
        check("flush_idex", 32'(flush_idex_o), 32'(tk));
        if (!r) begin
            m_pc = 32'h0;
            m_fv = 1'b0;
            m_mis = 1'b0;
            m_cnt = 32'h0;
            m_block = 0;
        end else begin
            m_pc = tk ? (tgt & 32'hFFFF_FFFC) : (s ? m_pc : m_pc + 32'd4);
            m_block = tk ? 2 : (m_block > 0 ? m_block - 1 : 0);
            m_mis = tk && (tgt % 4 != 0);
            if (tk && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            m_fv = 1'b1;
        end
        e.pc = m_pc;
        e.fv = m_fv;
        e.mis = m_mis;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", pc_o, e.pc);
        check("pc_plus4", pc_plus4_o, e.pc + 32'd4);
        check("fetch_valid", 32'(fetch_valid_o), 32'(e.fv));
        check("misaligned", 32'(misaligned_o), 32'(e.mis));
        check("count", redirect_count_o, e.cnt);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 32'h0);
    endtask
    initial begin
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 1, 32'h80);
        idle(4);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 1, 32'hDEAD_BEEF);
        idle(1);
        step(1, 1, 1, 1, 32'h100);
        idle(3);
        step(1, 0, 1, 1, 32'h200);
        step(1, 0, 1, 1, 32'h300);
        step(1, 1, 1, 1, 32'h300);
        step(1, 0, 1, 1, 32'h300);
        idle(3);
        step(1, 0, 1, 1, 32'h402);
        idle(3);
        step(1, 0, 1, 1, 32'hFFFF_FFFC);
        idle(3);
        @(negedge clk);
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 1, 32'h1000 + 32'(i) * 32'h40);
            idle(3);
        end
        step(1, 0, 1, 1, 32'h600);
        step(0, 0, 1, 1, 32'h700);
        step(1, 0, 1, 1, 32'h500);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
